seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 144 ++++++++++++++
 tb/tb_seq_divider.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, N+3-edge latency including the edge that takes load.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands with truncation toward zero.

module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         received,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         init,
  output logic         done,
  output logic         dbz
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    STEP  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [N-1:0]  rem, quo, dvsr;
  logic [CW-1:0] cnt;
  logic          dz;
  logic          cap_en, step_en, fix_en, ack_en;
  logic [N:0]    rem_sh, trial;
  logic [N-1:0]  a_mag, b_mag, q_fix, r_fix;

  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic en);
    return en ? (~v + N'(1)) : v;
  endfunction

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic signed [N-1:0] a_s, b_s;
  logic                a_neg, b_neg;

  assign a_s   = A;
  assign b_s   = B;
  assign a_mag = cond_neg(A, a_s[N-1]);
  assign b_mag = cond_neg(B, b_s[N-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_neg <= 1'b0;
      b_neg <= 1'b0;
    end else if (cap_en) begin
      a_neg <= a_s[N-1];
      b_neg <= b_s[N-1];
    end
  end

  // For a zero divisor quo still holds |A|, so re-applying A's sign returns A itself.
  assign q_fix = dz ? '1 : cond_neg(quo, a_neg ^ b_neg);
  assign r_fix = cond_neg(dz ? quo : rem, a_neg);
`else
  assign a_mag = A;
  assign b_mag = B;
  assign q_fix = dz ? '1 : quo;
  assign r_fix = dz ? quo : rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = INIT;
      INIT:    state_nx = (B == '0) ? FIXUP : STEP;
      STEP:    if (cnt == '0) state_nx = FIXUP;
      FIXUP:   state_nx = DONE;
      DONE:    if (received) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cap_en  = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    ack_en  = 1'b0;
    case (state)
      INIT:    cap_en  = 1'b1;
      STEP:    step_en = 1'b1;
      FIXUP:   fix_en  = 1'b1;
      DONE:    ack_en  = received;
      default: ;
    endcase
  end

  // rem < divisor always, so the shifted value fits N+1 bits and trial[N] is its sign.
  assign rem_sh = {rem, quo[N-1]};
  assign trial  = rem_sh - {1'b0, dvsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      dvsr <= '0;
      cnt  <= '0;
      dz   <= 1'b0;
      Q    <= '0;
      R    <= '0;
      init <= 1'b0;
      done <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      init <= cap_en;
      if (cap_en) begin
        quo  <= a_mag;
        dvsr <= b_mag;
        rem  <= '0;
        cnt  <= CW'(N - 1);
        dz   <= (B == '0);
      end
      if (step_en) begin
        rem <= trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
        quo <= {quo[N-2:0], ~trial[N]};
        cnt <= cnt - CW'(1);
      end
      if (fix_en) begin
        Q    <= q_fix;
        R    <= r_fix;
        dbz  <= dz;
        done <= 1'b1;
      end
      if (ack_en) begin
        done <= 1'b0;
        dbz  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (N=32); signed vectors apply when SEQ_DIVIDER_SIGNED_EN is defined.

module tb_seq_divider;
  localparam int N = 32;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         load     = 1'b0;
  logic         received = 1'b0;
  logic [N-1:0] A        = '0;
  logic [N-1:0] B        = '0;
  logic [N-1:0] Q, R;
  logic         init, done, dbz;

  int n_vec = 0;
  int n_err = 0;

  seq_divider #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .received (received),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .init     (init),
    .done     (done),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Edge 1 is the edge that samples load; counts edges until done is seen high.
  task automatic wait_done(input bit scramble, output int edges, output int inits);
    edges = 0;
    inits = 0;
    do begin
      @(negedge clk);
      edges++;
      if (init) inits++;
      if (scramble && edges >= 2) begin
        A    = $urandom;
        B    = $urandom;
        load = edges[0];
      end else begin
        load = 1'b0;
      end
    end while (!done && edges < 200);
    load = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit scramble, input logic [N-1:0] q_exp,
                         input logic [N-1:0] r_exp, input logic dbz_exp, input int edges_exp);
    int edges, inits;
    @(negedge clk);
    A    = a;
    B    = b;
    load = 1'b1;
    wait_done(scramble, edges, inits);
    expect_eq({tag, "_done"},  done,  1);
    expect_eq({tag, "_q"},     Q,     q_exp);
    expect_eq({tag, "_r"},     R,     r_exp);
    expect_eq({tag, "_dbz"},   dbz,   dbz_exp);
    expect_eq({tag, "_edges"}, edges, edges_exp);
    expect_eq({tag, "_init"},  inits, 1);
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    expect_eq({tag, "_ack_done"}, done, 0);
    expect_eq({tag, "_ack_dbz"},  dbz,  0);
  endtask

  initial begin
    int  edges, inits;
    bit  stable;

    repeat (2) @(negedge clk);
    expect_eq("rst_q",    Q, 0);
    expect_eq("rst_r",    R, 0);
    expect_eq("rst_ctl",  {done, init, dbz}, 0);
    rst_n = 1'b1;

    run_div("u7d2", 32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 1'b0, N + 3);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(done && Q == 32'd3 && R == 32'd1)) stable = 1'b0;
    end
    expect_eq("hold_stable", stable, 1);
    expect_eq("hold_done",   done,   1);
    ack("u7d2");

    run_div("dz", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 3);
    ack("dz");
    run_div("max_d1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, N + 3);
    ack("max_d1");
    run_div("max_dmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, N + 3);
    ack("max_dmax");
    run_div("small", 32'd5, 32'd7, 1'b0, 32'd0, 32'd5, 1'b0, N + 3);
    ack("small");

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("sn7d2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, N + 3);
    ack("sn7d2");
    run_div("s7dn2", 32'd7, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 32'd1, 1'b0, N + 3);
    ack("s7dn2");
    run_div("sn7dn2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'd3, 32'hFFFF_FFFF, 1'b0, N + 3);
    ack("sn7dn2");
    run_div("smin_dn1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0, 1'b0, N + 3);
    ack("smin_dn1");
    run_div("sdz_neg", 32'hFFFF_FF9C, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 3);
    ack("sdz_neg");
`else
    run_div("u_beef", 32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, N + 3);
    ack("u_beef");
    run_div("u_big", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, N + 3);
    ack("u_big");
`endif

    run_div("scr", 32'd123456789, 32'd1000, 1'b1, 32'd123456, 32'd789, 1'b0, N + 3);
    ack("scr");

    // Abort in the middle of the STEP iterations.
    @(negedge clk);
    A    = 32'd1000;
    B    = 32'd3;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    expect_eq("mid_rst_q",   Q, 0);
    expect_eq("mid_rst_r",   R, 0);
    expect_eq("mid_rst_ctl", {done, init, dbz}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    expect_eq("abort_no_done", done, 0);
    run_div("after_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, N + 3);
    ack("after_rst");

    // Acknowledge and new load in the same DONE cycle.
    run_div("pre", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, N + 3);
    @(negedge clk);
    A        = 32'd1000;
    B        = 32'd7;
    load     = 1'b1;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    expect_eq("both_idle_done", done, 0);
    wait_done(1'b0, edges, inits);
    expect_eq("both_done",  done,  1);
    expect_eq("both_q",     Q,     32'd142);
    expect_eq("both_r",     R,     32'd6);
    expect_eq("both_edges", edges, N + 3);
    ack("both");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
